microwave_timer: RTL and testbench



---
 rtl/microwave_timer.sv | 103 ++++++++++
 tb/tb_microwave_timer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// ---------------------------------------------------------------------------
// microwave_timer
//
// Three-digit BCD countdown timer (m:ss) for the microwave controller.
// Digits are entered one at a time from the keypad encoder by shifting left.
// While enabled, the time is decremented by one second per clock edge.
// Counting stops at 0:00 and does not wrap.
//
// Ports
//   clk       in   1  1 Hz timing clock; all state changes on the rising edge
//   clearn    in   1  synchronous active-low clear (all digits -> 0)
//   loadn     in   1  active-low digit load, one left shift per edge while low
//   EN        in   1  active-high count enable, one decrement per edge
//   data      in   4  BCD digit from the keypad (values above 9 stored as 9)
//   sec_ones  out  4  seconds units digit
//   sec_tens  out  4  seconds tens digit (0-9; 6-9 only after keypad entry)
//   mins      out  4  minutes digit
//   zero      out  1  high while all three digits are 0
// ---------------------------------------------------------------------------
module microwave_timer (
    input  logic       clk,
    input  logic       clearn,
    input  logic       loadn,
    input  logic       EN,
    input  logic [3:0] data,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero
);

    // Keypad digits above 9 are not valid BCD; store the largest legal digit.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        logic [3:0] result;
        if (digit > 4'd9) begin
            result = 4'd9;
        end else begin
            result = digit;
        end
        return result;
    endfunction

    logic [3:0] sec_ones_r;
    logic [3:0] sec_tens_r;
    logic [3:0] mins_r;

    logic [3:0] data_clamped_s;
    logic [3:0] sec_ones_dec_s;
    logic [3:0] sec_tens_dec_s;
    logic [3:0] mins_dec_s;
    logic       time_zero_s;

    assign data_clamped_s = clamp_bcd(data);
    assign time_zero_s    = (mins_r == 4'd0) && (sec_tens_r == 4'd0) && (sec_ones_r == 4'd0);

    // Next value of the digits for a one-second BCD decrement with borrow.
    // Only used when the time is nonzero, so mins never underflows here.
    // A tens digit of 6-9 is decremented like any other nonzero digit.
    always_comb begin
        sec_ones_dec_s = sec_ones_r;
        sec_tens_dec_s = sec_tens_r;
        mins_dec_s     = mins_r;
        if (sec_ones_r != 4'd0) begin
            sec_ones_dec_s = sec_ones_r - 4'd1;
        end else begin
            sec_ones_dec_s = 4'd9;
            if (sec_tens_r != 4'd0) begin
                sec_tens_dec_s = sec_tens_r - 4'd1;
            end else begin
                sec_tens_dec_s = 4'd5;
                mins_dec_s     = mins_r - 4'd1;
            end
        end
    end

    // Digit registers: clear, then shift-in load, then count, then hold.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            sec_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            mins_r     <= 4'd0;
        end else if (!loadn) begin
            mins_r     <= sec_tens_r;
            sec_tens_r <= sec_ones_r;
            sec_ones_r <= data_clamped_s;
        end else if (EN && !time_zero_s) begin
            sec_ones_r <= sec_ones_dec_s;
            sec_tens_r <= sec_tens_dec_s;
            mins_r     <= mins_dec_s;
        end else begin
            sec_ones_r <= sec_ones_r;
            sec_tens_r <= sec_tens_r;
            mins_r     <= mins_r;
        end
    end

    assign sec_ones = sec_ones_r;
    assign sec_tens = sec_tens_r;
    assign mins     = mins_r;
    // zero follows the digit registers directly so it rises with 0:00.
    assign zero     = time_zero_s;

endmodule

// File: tb/tb_microwave_timer.sv
// ---------------------------------------------------------------------------
// tb_microwave_timer
//
// Self-checking bench for microwave_timer. The reference model keeps the
// displayed time as one decimal number m*100 + t*10 + s: a load is
// "drop the hundreds, times ten, plus the clamped digit", and a count step
// is "minus 1", except that a whole minute (xx00) becomes (x-1)59, i.e.
// "minus 41". Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_microwave_timer;

    logic       clk;
    logic       clearn;
    logic       loadn;
    logic       EN;
    logic [3:0] data;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;

    int tests_run;
    int tests_failed;
    int model_val;

    microwave_timer dut (
        .clk      (clk),
        .clearn   (clearn),
        .loadn    (loadn),
        .EN       (EN),
        .data     (data),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {mins, sec_tens, sec_ones, zero} from the decimal model value.
    function automatic logic [12:0] model_vec(input int v);
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] s;
        m = 4'(v / 100);
        t = 4'((v / 10) % 10);
        s = 4'(v % 10);
        return {m, t, s, (v == 0)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {mins, sec_tens, sec_ones, zero};
    endfunction

    // One rising edge: advance the model from the inputs sampled at that edge,
    // then move 1 time unit past the edge so outputs are stable for checking.
    task automatic tick();
        int d;
        @(posedge clk);
        d = (data > 4'd9) ? 9 : int'(data);
        if (!clearn) begin
            model_val = 0;
        end else if (!loadn) begin
            model_val = (model_val % 100) * 10 + d;
        end else if (EN && model_val != 0) begin
            if (model_val % 100 == 0) model_val = model_val - 41;
            else                      model_val = model_val - 1;
        end
        #1;
    endtask

    task automatic do_clear();
        clearn = 1'b0; loadn = 1'b1; EN = 1'b0;
        tick();
        clearn = 1'b1;
    endtask

    task automatic load_digit(input logic [3:0] d);
        loadn = 1'b0; EN = 1'b0; data = d;
        tick();
        loadn = 1'b1;
    endtask

    task automatic count(input int n);
        EN = 1'b1; loadn = 1'b1;
        for (int i = 0; i < n; i++) tick();
        EN = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        tests_run++;
        if (dut_vec() !== 13'h0001) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h", dut_vec(), 13'h0001);
        end
    endtask

    task automatic test_load_hold();
        load_digit(4'd5);
        tests_run++;
        if (dut_vec() !== {4'd0, 4'd0, 4'd5, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_5: got %h expected %h", dut_vec(), {4'd0, 4'd0, 4'd5, 1'b0});
        end
        EN = 1'b0; loadn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (dut_vec() !== {4'd0, 4'd0, 4'd5, 1'b0}) begin
                tests_failed++;
                $display("FAIL hold_%0d: got %h expected %h", i, dut_vec(), {4'd0, 4'd0, 4'd5, 1'b0});
            end
        end
    endtask

    task automatic test_countdown();
        EN = 1'b1; loadn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests_run++;
            if (dut_vec() !== model_vec(model_val)) begin
                tests_failed++;
                $display("FAIL countdown_%0d: got %h expected %h", i, dut_vec(), model_vec(model_val));
            end
        end
        EN = 1'b0;
        tests_run++;
        if (dut_vec() !== 13'h0001) begin
            tests_failed++;
            $display("FAIL countdown_stop: got %h expected %h", dut_vec(), 13'h0001);
        end
    endtask

    task automatic test_multi_digit();
        do_clear();
        load_digit(4'd1); load_digit(4'd3); load_digit(4'd0);
        tests_run++;
        if (dut_vec() !== {4'd1, 4'd3, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL entry_130: got %h expected %h", dut_vec(), {4'd1, 4'd3, 4'd0, 1'b0});
        end
        count(3);
        tests_run++;
        if (dut_vec() !== {4'd1, 4'd2, 4'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL count_127: got %h expected %h", dut_vec(), {4'd1, 4'd2, 4'd7, 1'b0});
        end
        do_clear();
        load_digit(4'd1); load_digit(4'd0); load_digit(4'd0);
        count(1);
        tests_run++;
        if (dut_vec() !== {4'd0, 4'd5, 4'd9, 1'b0}) begin
            tests_failed++;
            $display("FAIL borrow_100: got %h expected %h", dut_vec(), {4'd0, 4'd5, 4'd9, 1'b0});
        end
    endtask

    task automatic test_borrow();
        do_clear();
        load_digit(4'd2); load_digit(4'd0); load_digit(4'd0);
        count(1);
        tests_run++;
        if (dut_vec() !== {4'd1, 4'd5, 4'd9, 1'b0}) begin
            tests_failed++;
            $display("FAIL borrow_200: got %h expected %h", dut_vec(), {4'd1, 4'd5, 4'd9, 1'b0});
        end
        do_clear();
        load_digit(4'd9); load_digit(4'd9);
        count(1);
        tests_run++;
        if (dut_vec() !== {4'd0, 4'd9, 4'd8, 1'b0}) begin
            tests_failed++;
            $display("FAIL count_098: got %h expected %h", dut_vec(), {4'd0, 4'd9, 4'd8, 1'b0});
        end
        count(8);
        tests_run++;
        if (dut_vec() !== {4'd0, 4'd9, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL count_090: got %h expected %h", dut_vec(), {4'd0, 4'd9, 4'd0, 1'b0});
        end
        count(1);
        tests_run++;
        if (dut_vec() !== {4'd0, 4'd8, 4'd9, 1'b0}) begin
            tests_failed++;
            $display("FAIL count_089: got %h expected %h", dut_vec(), {4'd0, 4'd8, 4'd9, 1'b0});
        end
    endtask

    task automatic test_priority();
        // 0:89 -> load 12 with EN high: shift only, clamped -> 8:99
        loadn = 1'b0; EN = 1'b1; data = 4'd12;
        tick();
        loadn = 1'b1;
        tests_run++;
        if (dut_vec() !== {4'd8, 4'd9, 4'd9, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_over_en_clamp: got %h expected %h", dut_vec(), {4'd8, 4'd9, 4'd9, 1'b0});
        end
        count(2);
        tests_run++;
        if (dut_vec() !== {4'd8, 4'd9, 4'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL count_897: got %h expected %h", dut_vec(), {4'd8, 4'd9, 4'd7, 1'b0});
        end
        clearn = 1'b0; loadn = 1'b0; EN = 1'b1; data = 4'd3;
        tick();
        clearn = 1'b1; loadn = 1'b1; EN = 1'b0;
        tests_run++;
        if (dut_vec() !== 13'h0001) begin
            tests_failed++;
            $display("FAIL clear_over_all: got %h expected %h", dut_vec(), 13'h0001);
        end
    endtask

    task automatic test_unsampled_clear();
        load_digit(4'd4); load_digit(4'd2);
        // clearn pulses low strictly between two rising edges
        #2 clearn = 1'b0;
        #2 clearn = 1'b1;
        EN = 1'b0; loadn = 1'b1;
        tick();
        tests_run++;
        if (dut_vec() !== {4'd0, 4'd4, 4'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL unsampled_clear: got %h expected %h", dut_vec(), {4'd0, 4'd4, 4'd2, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clearn = ($urandom_range(0, 19) != 0);
            loadn  = ($urandom_range(0, 3) != 0);
            EN     = $urandom_range(0, 1) == 1;
            data   = 4'($urandom_range(0, 15));
            tick();
            tests_run++;
            if (dut_vec() !== model_vec(model_val)) begin
                tests_failed++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), model_vec(model_val));
            end
        end
        clearn = 1'b1; loadn = 1'b1; EN = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_val    = 0;
        clearn = 1'b1; loadn = 1'b1; EN = 1'b0; data = 4'd0;
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_countdown();
        test_multi_digit();
        test_borrow();
        test_priority();
        test_unsampled_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
